// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier. A single 4x4 array multiplier handles one nibble pair per cycle,
// so each product takes four MUL steps and is presented with a one-cycle done pulse.
module mul8_seq_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] prod
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DONE
   } state_t;

   state_t      r_state;
   logic [1:0]  r_step;
   logic [7:0]  r_a;
   logic [7:0]  r_b;
   logic [15:0] r_acc;
   logic [15:0] r_prod;
   logic        r_busy;
   logic        r_done;

   logic [3:0]  w_mx;
   logic [3:0]  w_my;
   logic [7:0]  w_pp;
   logic [15:0] w_pp_sh;
   logic [15:0] w_sum;

   // Step order: lo*lo, hi*lo, lo*hi, hi*hi
   always_comb begin
      w_mx = r_a[3:0];
      w_my = r_b[3:0];
      case (r_step)
         2'd0: begin w_mx = r_a[3:0]; w_my = r_b[3:0]; end
         2'd1: begin w_mx = r_a[7:4]; w_my = r_b[3:0]; end
         2'd2: begin w_mx = r_a[3:0]; w_my = r_b[7:4]; end
         default: begin w_mx = r_a[7:4]; w_my = r_b[7:4]; end
      endcase
   end

   // 4x4 array multiplier: one gated, shifted row of the multiplicand per multiplier bit
   always_comb begin
      w_pp = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (w_my[i]) begin
            w_pp = w_pp + ({4'b0000, w_mx} << i);
         end
      end
   end

   always_comb begin
      w_pp_sh = '0;
      case (r_step)
         2'd0:    w_pp_sh = {8'h00, w_pp};
         2'd1,
         2'd2:    w_pp_sh = {4'h0, w_pp, 4'h0};
         default: w_pp_sh = {w_pp, 8'h00};
      endcase
   end

   assign w_sum = r_acc + w_pp_sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_step  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_prod  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE,
            S_DONE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_acc   <= '0;
                  r_step  <= '0;
                  r_state <= S_MUL;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            end
            S_MUL: begin
               r_acc  <= w_sum;
               r_step <= r_step + 2'd1;
               if (r_step == 2'd3) begin
                  r_prod  <= w_sum;
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign prod = r_prod;

endmodule
